// File: rtl/tblink_rpc_hdl_invoke_initiator.sv
// ---------------------------------------------------------------------------
// tblink_rpc_hdl_invoke_initiator
//
// HDL-side initiator for TbLink RPC calls. RTL issues one-parameter method
// calls on the req_* port. Each accepted call receives a call_id and is
// serialized onto the tx_* word stream as a 2-word request:
//   word 0 (header): [31:24]=method_id, [23:16]=call_id (zero-extended),
//                    [15]=blocking, all other bits 0
//   word 1         : parameter, tx_last=1
// Responses come back on rx_* as a header ([23:16]=call_id) followed by a
// return word with rx_last=1. A response whose id is pending is delivered on
// rsp_*. Completions are delivered in arrival order.
//
// Handshakes: every stream (req, tx, rx, rsp) transfers a beat on a rising
// clock edge where valid && ready are both 1. A producer holding valid keeps
// its payload stable until that edge; ready may change freely.
//
// Ports
//   clock, reset_n            clock, asynchronous active-low reset
//   req_valid/req_ready       call request handshake
//   req_method_id/blocking    call header fields
//   req_param                 call parameter
//   req_call_id               id given to the call accepted this cycle
//   tx_valid/ready/data/last  outbound request word stream
//   rx_valid/ready/data/last  inbound response word stream
//   rsp_valid/ready/call_id/data  completed-call delivery to the user
//   outstanding               issued but not yet retired calls
//   err_unknown_id            1-cycle pulse: response id not pending
//   err_proto                 1-cycle pulse: response framing error
//   dbg_tx_state/dbg_rx_state FSM state encodings for observation
// ---------------------------------------------------------------------------
module tblink_rpc_hdl_invoke_initiator #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  // call request from user RTL
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [7:0]        req_method_id,
  input  logic              req_blocking,
  input  logic [DATA_W-1:0] req_param,
  output logic [ID_W-1:0]   req_call_id,
  // outbound request stream
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_last,
  // inbound response stream
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_last,
  // completed-call delivery
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_call_id,
  output logic [DATA_W-1:0] rsp_data,
  // status
  output logic [ID_W:0]     outstanding,
  output logic              err_unknown_id,
  output logic              err_proto,
  output logic [1:0]        dbg_tx_state,
  output logic [1:0]        dbg_rx_state
);

  localparam int NUM_IDS = 1 << ID_W;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_HDR   = 2'd1,
    TX_PARAM = 2'd2
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_HDR     = 2'd0,
    RX_DATA    = 2'd1,
    RX_DELIVER = 2'd2,
    RX_DRAIN   = 2'd3
  } rx_state_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  tx_state_t           tx_state_q;
  logic [ID_W-1:0]     next_id_q;
  logic [DATA_W-1:0]   param_q;
  logic                tx_valid_q;
  logic [DATA_W-1:0]   tx_data_q;
  logic                tx_last_q;

  logic [NUM_IDS-1:0]  pending_q, pending_d;
  logic [ID_W:0]       outstanding_q, outstanding_d;

  rx_state_t           rx_state_q;
  logic [7:0]          rx_id_q;
  logic                rsp_valid_q;
  logic [ID_W-1:0]     rsp_call_id_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                err_unknown_q;
  logic                err_proto_q;

  // ---------------------------------------------------------------------
  // Handshake qualifiers
  // ---------------------------------------------------------------------
  logic              req_fire;
  logic              rsp_fire;
  logic              rx_fire;
  logic [DATA_W-1:0] hdr_word;
  logic [ID_W-1:0]   rx_idx;
  logic              rx_id_known;

  // Ready outputs are gated by reset_n so every output reads 0 in reset.
  // Issue is strictly sequential: if next_id is still pending we stall even
  // when other ids are free.
  assign req_ready = reset_n && (tx_state_q == TX_IDLE) && !pending_q[next_id_q];
  assign rx_ready  = reset_n && (rx_state_q != RX_DELIVER);

  assign req_fire  = req_valid && req_ready;
  assign rsp_fire  = rsp_valid_q && rsp_ready;
  assign rx_fire   = rx_valid && rx_ready;

  // Header id field is 8 bits wide; ids that do not fit ID_W are never pending.
  assign rx_idx      = rx_id_q[ID_W-1:0];
  assign rx_id_known = ((rx_id_q >> ID_W) == 8'd0);

  always_comb begin
    hdr_word        = '0;
    hdr_word[31:24] = req_method_id;
    hdr_word[23:16] = 8'(next_id_q);
    hdr_word[15]    = req_blocking;
  end

  // Allocation needs the bit clear and retirement needs it set, so the two
  // updates below never touch the same bit in one cycle.
  always_comb begin
    pending_d = pending_q;
    if (req_fire) pending_d[next_id_q]     = 1'b1;
    if (rsp_fire) pending_d[rsp_call_id_q] = 1'b0;
  end

  always_comb begin
    outstanding_d = outstanding_q;
    case ({req_fire, rsp_fire})
      2'b10:   outstanding_d = outstanding_q + (ID_W+1)'(1);
      2'b01:   outstanding_d = outstanding_q - (ID_W+1)'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_q     <= '0;
      outstanding_q <= '0;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
    end
  end

  // ---------------------------------------------------------------------
  // TX FSM: IDLE -> HDR -> PARAM -> IDLE. The header is built from the live
  // request fields at accept time; the parameter is latched for word 2.
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q <= TX_IDLE;
      next_id_q  <= '0;
      param_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_last_q  <= 1'b0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (req_fire) begin
            next_id_q  <= next_id_q + 1'b1;
            param_q    <= req_param;
            tx_valid_q <= 1'b1;
            tx_data_q  <= hdr_word;
            tx_last_q  <= 1'b0;
            tx_state_q <= TX_HDR;
          end
        end
        TX_HDR: begin
          if (tx_ready) begin
            tx_data_q  <= param_q;
            tx_last_q  <= 1'b1;
            tx_state_q <= TX_PARAM;
          end
        end
        TX_PARAM: begin
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            tx_state_q <= TX_IDLE;
          end
        end
        default: begin
          tx_valid_q <= 1'b0;
          tx_last_q  <= 1'b0;
          tx_state_q <= TX_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // RX FSM: HDR -> DATA -> DELIVER -> HDR, with DRAIN to resynchronise on
  // a return word that is not marked last. Error flags are single-cycle.
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q    <= RX_HDR;
      rx_id_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_call_id_q <= '0;
      rsp_data_q    <= '0;
      err_unknown_q <= 1'b0;
      err_proto_q   <= 1'b0;
    end else begin
      err_unknown_q <= 1'b0;
      err_proto_q   <= 1'b0;
      case (rx_state_q)
        RX_HDR: begin
          if (rx_fire) begin
            if (rx_last) begin
              // a one-word response has no return value
              err_proto_q <= 1'b1;
            end else begin
              rx_id_q    <= rx_data[23:16];
              rx_state_q <= RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (rx_fire) begin
            if (!rx_last) begin
              err_proto_q <= 1'b1;
              rx_state_q  <= RX_DRAIN;
            end else if (rx_id_known && pending_q[rx_idx]) begin
              rsp_valid_q   <= 1'b1;
              rsp_call_id_q <= rx_idx;
              rsp_data_q    <= rx_data;
              rx_state_q    <= RX_DELIVER;
            end else begin
              err_unknown_q <= 1'b1;
              rx_state_q    <= RX_HDR;
            end
          end
        end
        RX_DELIVER: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rx_state_q  <= RX_HDR;
          end
        end
        RX_DRAIN: begin
          if (rx_fire && rx_last) rx_state_q <= RX_HDR;
        end
        default: rx_state_q <= RX_HDR;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign req_call_id    = next_id_q;
  assign tx_valid       = tx_valid_q;
  assign tx_data        = tx_data_q;
  assign tx_last        = tx_last_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_call_id    = rsp_call_id_q;
  assign rsp_data       = rsp_data_q;
  assign outstanding    = outstanding_q;
  assign err_unknown_id = err_unknown_q;
  assign err_proto      = err_proto_q;
  assign dbg_tx_state   = tx_state_q;
  assign dbg_rx_state   = rx_state_q;

endmodule

// File: tb/tb_tblink_rpc_hdl_invoke_initiator.sv
// ---------------------------------------------------------------------------
// Self-checking bench for tblink_rpc_hdl_invoke_initiator (DATA_W=32, ID_W=2).
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_tblink_rpc_hdl_invoke_initiator;

  localparam int DATA_W = 32;
  localparam int ID_W   = 2;

  localparam logic [1:0] RX_HDR     = 2'd0;
  localparam logic [1:0] RX_DATA    = 2'd1;
  localparam logic [1:0] RX_DELIVER = 2'd2;
  localparam logic [1:0] RX_DRAIN   = 2'd3;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic              req_valid, req_ready, req_blocking;
  logic [7:0]        req_method_id;
  logic [DATA_W-1:0] req_param;
  logic [ID_W-1:0]   req_call_id;
  logic              tx_valid, tx_ready, tx_last;
  logic [DATA_W-1:0] tx_data;
  logic              rx_valid, rx_ready, rx_last;
  logic [DATA_W-1:0] rx_data;
  logic              rsp_valid, rsp_ready;
  logic [ID_W-1:0]   rsp_call_id;
  logic [DATA_W-1:0] rsp_data;
  logic [ID_W:0]     outstanding;
  logic              err_unknown_id, err_proto;
  logic [1:0]        dbg_tx_state, dbg_rx_state;

  tblink_rpc_hdl_invoke_initiator #(.DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_method_id(req_method_id),
    .req_blocking(req_blocking), .req_param(req_param), .req_call_id(req_call_id),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_last(rx_last),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_call_id(rsp_call_id),
    .rsp_data(rsp_data), .outstanding(outstanding),
    .err_unknown_id(err_unknown_id), .err_proto(err_proto),
    .dbg_tx_state(dbg_tx_state), .dbg_rx_state(dbg_rx_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [DATA_W:0] exp_q[$];   // {tx_last, tx_data} expected in order

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset_n = 1'b0;
    req_valid = 1'b0; req_method_id = '0; req_blocking = 1'b0; req_param = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0; rx_last = 1'b0; rsp_ready = 1'b0;
    exp_q.delete();
    @(negedge clock);
    @(negedge clock);
    check("rst_req_ready", req_ready, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_status", {rsp_valid, err_unknown_id, err_proto, outstanding}, 0);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  // Present a call and wait for acceptance; queue the expected tx words.
  task automatic issue(input logic [7:0] m, input logic b, input logic [31:0] p,
                       input logic [ID_W-1:0] eid, input logic [31:0] ehdr);
    req_method_id = m; req_blocking = b; req_param = p; req_valid = 1'b1;
    for (int k = 0; k < 20 && !req_ready; k++) @(negedge clock);
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout: req_ready got 0 expected 1");
      req_valid = 1'b0;
    end else begin
      check("req_call_id", req_call_id, eid);
      exp_q.push_back({1'b0, ehdr});
      exp_q.push_back({1'b1, p});
      @(negedge clock);
      req_valid = 1'b0;
    end
  endtask

  // Accept n words on tx with tx_ready=1 and compare them against exp_q.
  task automatic collect_tx(input int n);
    int got;
    logic [DATA_W:0] e;
    got = 0;
    tx_ready = 1'b1;
    for (int k = 0; k < 20 && got < n; k++) begin
      if (tx_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("tx_word", {tx_last, tx_data}, e);
        got++;
      end
      @(negedge clock);
    end
    check("tx_count", got, n);
  endtask

  // Drive one rx word; returns on the falling edge after it was accepted.
  task automatic send_word(input logic [31:0] d, input logic l);
    rx_data = d; rx_last = l; rx_valid = 1'b1;
    for (int k = 0; k < 20 && !rx_ready; k++) @(negedge clock);
    if (!rx_ready) begin
      checks++; errors++;
      $display("FAIL rx_timeout: rx_ready got 0 expected 1");
    end
    @(negedge clock);
    rx_valid = 1'b0; rx_last = 1'b0;
  endtask

  function automatic logic [31:0] rsp_hdr(input logic [7:0] id);
    return {8'h00, id, 16'h0000};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]      method;
    logic            blk;
    logic [31:0]     param;
    logic [31:0]     ret;
    logic [ID_W-1:0] exp_id;
    logic [31:0]     exp_hdr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{8'h05, 1'b0, 32'h0000_1234, 32'h0000_CAFE, 2'd0, 32'h0500_0000};
    vecs[1] = '{8'hA7, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 2'd1, 32'hA701_8000};
    vecs[2] = '{8'hFF, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 2'd2, 32'hFF02_8000};
    vecs[3] = '{8'h00, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 2'd3, 32'h0003_0000};
    vecs[4] = '{8'h3C, 1'b0, 32'h5A5A_5A5A, 32'hA5A5_A5A5, 2'd0, 32'h3C00_0000};

    do_reset();
    check("post_rst_call_id", req_call_id, 0);
    check("post_rst_req_ready", req_ready, 1);

    // Single call round trip per vector; id wraps on the fifth.
    for (int i = 0; i < 5; i++) begin
      tx_ready = 1'b1;
      issue(vecs[i].method, vecs[i].blk, vecs[i].param, vecs[i].exp_id, vecs[i].exp_hdr);
      check("outst_after_issue", outstanding, 1);
      collect_tx(2);
      check("tx_idle", tx_valid, 0);
      send_word(rsp_hdr(8'(vecs[i].exp_id)), 1'b0);
      check("rx_state_data", dbg_rx_state, RX_DATA);
      send_word(vecs[i].ret, 1'b1);
      check("rsp_valid", rsp_valid, 1);
      check("rsp_call_id", rsp_call_id, vecs[i].exp_id);
      check("rsp_data", rsp_data, vecs[i].ret);
      check("rx_ready_deliver", rx_ready, 0);
      rsp_ready = 1'b1;
      @(negedge clock);
      rsp_ready = 1'b0;
      check("rsp_done", rsp_valid, 0);
      check("outst_after_rsp", outstanding, 0);
    end

    // Full table: four calls outstanding, then retire id 0 to reopen issue.
    do_reset();
    issue(8'h10, 1'b0, 32'h100, 2'd0, 32'h1000_0000); collect_tx(2);
    issue(8'h11, 1'b0, 32'h101, 2'd1, 32'h1101_0000); collect_tx(2);
    issue(8'h12, 1'b0, 32'h102, 2'd2, 32'h1202_0000); collect_tx(2);
    issue(8'h13, 1'b0, 32'h103, 2'd3, 32'h1303_0000); collect_tx(2);
    check("full_outst", outstanding, 4);
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("full_stall", req_ready, 0);
      @(negedge clock);
    end
    check("full_no_tx", tx_valid, 0);
    req_valid = 1'b0;
    send_word(rsp_hdr(8'd0), 1'b0);
    send_word(32'h0000_00A0, 1'b1);
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    check("freed_req_ready", req_ready, 1);
    check("freed_call_id", req_call_id, 0);
    check("freed_outst", outstanding, 3);
    issue(8'h14, 1'b1, 32'h104, 2'd0, 32'h1400_8000); collect_tx(2);
    // Retire id 2 while next_id=1 is still pending: issue must stay stalled.
    send_word(rsp_hdr(8'd2), 1'b0);
    send_word(32'h0000_00A2, 1'b1);
    check("rsp_id2", rsp_call_id, 2);
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    check("seq_stall", req_ready, 0);
    check("seq_outst", outstanding, 3);

    // Unknown id: only 0 and 1 pending, reply for 3.
    do_reset();
    tx_ready = 1'b1;
    issue(8'h20, 1'b0, 32'h200, 2'd0, 32'h2000_0000); collect_tx(2);
    issue(8'h21, 1'b0, 32'h201, 2'd1, 32'h2101_0000); collect_tx(2);
    send_word(rsp_hdr(8'd3), 1'b0);
    send_word(32'h0000_0BAD, 1'b1);
    check("unk_pulse", err_unknown_id, 1);
    check("unk_no_rsp", rsp_valid, 0);
    check("unk_outst", outstanding, 2);
    @(negedge clock);
    check("unk_pulse_end", err_unknown_id, 0);
    check("unk_rx_hdr", dbg_rx_state, RX_HDR);

    // Framing errors: single-word response, then return word without last.
    send_word(rsp_hdr(8'd0), 1'b1);
    check("proto_hdr_last", err_proto, 1);
    check("proto_stay_hdr", dbg_rx_state, RX_HDR);
    @(negedge clock);
    check("proto_pulse_end", err_proto, 0);
    send_word(rsp_hdr(8'd0), 1'b0);
    send_word(32'h0000_1111, 1'b0);
    check("proto_data_nolast", err_proto, 1);
    check("proto_drain", dbg_rx_state, RX_DRAIN);
    check("proto_no_rsp", rsp_valid, 0);
    send_word(32'h0000_2222, 1'b0);
    check("drain_hold", dbg_rx_state, RX_DRAIN);
    send_word(32'h0000_3333, 1'b1);
    check("drain_exit", dbg_rx_state, RX_HDR);
    check("drain_outst", outstanding, 2);
    check("drain_no_rsp", rsp_valid, 0);
    send_word(rsp_hdr(8'd1), 1'b0);
    send_word(32'h0000_BEEF, 1'b1);
    check("recover_id", rsp_call_id, 1);
    check("recover_data", rsp_data, 32'h0000_BEEF);
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    check("recover_outst", outstanding, 1);

    // Back-pressure on tx and rsp.
    do_reset();
    tx_ready = 1'b0;
    issue(8'h42, 1'b1, 32'h0BAD_F00D, 2'd0, 32'h4200_8000);
    for (int k = 0; k < 3; k++) begin
      check("bp_tx_hold", {tx_valid, tx_last, tx_data}, {1'b1, 1'b0, 32'h4200_8000});
      @(negedge clock);
    end
    collect_tx(2);
    send_word(rsp_hdr(8'd0), 1'b0);
    send_word(32'h0000_600D, 1'b1);
    for (int k = 0; k < 3; k++) begin
      check("bp_rsp_hold", {rsp_valid, rsp_data}, {1'b1, 32'h0000_600D});
      check("bp_rx_blocked", rx_ready, 0);
      @(negedge clock);
    end
    check("bp_deliver", dbg_rx_state, RX_DELIVER);
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    check("bp_done", {rsp_valid, rx_ready}, 2'b01);
    check("bp_outst", outstanding, 0);

    // Reset in the middle of a request discards it.
    tx_ready = 1'b0;
    issue(8'h55, 1'b0, 32'h5555, 2'd1, 32'h5501_0000);
    check("mid_tx_valid", tx_valid, 1);
    do_reset();
    check("mid_after_tx", tx_valid, 0);
    check("mid_after_id", req_call_id, 0);
    check("mid_after_outst", outstanding, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
